// File: rtl/data_path_pkg.sv
// Shared definitions for the single-bus CPU datapath: IR field layout,
// branch condition codes, ALU operation encoding and small helpers.
package data_path_pkg;

    localparam int DATA_W  = 32;
    localparam int NUM_GPR = 16;
    localparam int SEL_W   = 4;

    // IR field positions
    localparam int RA_LSB  = 23;
    localparam int RB_LSB  = 19;
    localparam int RC_LSB  = 15;
    localparam int C2_LSB  = 19;
    localparam int IMM_MSB = 18;

    typedef enum logic [1:0] {
        BR_ZR = 2'b00,
        BR_NZ = 2'b01,
        BR_PL = 2'b10,
        BR_MI = 2'b11
    } branch_e;

    typedef enum logic [2:0] {
        ALU_PASS,
        ALU_INCPC,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_NEG,
        ALU_NOT
    } alu_op_e;

    // Floating or unknown control lines must behave as deasserted.
    function automatic logic asserted(input logic s);
        return (s === 1'b1);
    endfunction

    function automatic logic branch_taken(input branch_e code, input logic [DATA_W-1:0] value);
        logic taken;
        taken = 1'b0;
        case (code)
            BR_ZR: taken = (value == '0);
            BR_NZ: taken = (value != '0);
            BR_PL: taken = ~value[DATA_W-1];
            BR_MI: taken = value[DATA_W-1];
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/data_path_alu.sv
// Combinational ALU: A comes from Y, B from the bus; 64-bit result whose
// upper half sign-extends the 32-bit result (zero upper half for pass-through).
module data_path_alu
    import data_path_pkg::*;
(
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  alu_op_e             op,
    output logic [2*DATA_W-1:0] result
);

    logic [DATA_W-1:0] r32;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        r32 = b;
        case (op)
            ALU_INCPC: r32 = b + 32'd1;
            ALU_ADD:   r32 = a + b;
            ALU_SUB:   r32 = a - b;
            ALU_AND:   r32 = a & b;
            ALU_OR:    r32 = a | b;
            ALU_NEG:   r32 = '0 - b;
            ALU_NOT:   r32 = ~b;
            default:   r32 = b;
        endcase

        if (op == ALU_PASS) begin
            result = {{DATA_W{1'b0}}, b};
        end else begin
            result = {{DATA_W{r32[DATA_W-1]}}, r32};
        end
    end

endmodule

// File: rtl/data_path.sv
// Single-bus 32-bit CPU datapath: GPR file, PC/IR/MAR/MDR/Y/Z registers,
// prioritised bus mux, Ra/Rb/Rc select/encode, ALU and branch CON flip-flop.
module data_path
    import data_path_pkg::*;
(
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] Mdatain,
    input  logic              MD_read,
    input  logic              Read,
    input  logic              Write,
    input  logic              PCin,
    input  logic              IRin,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Yin,
    input  logic              Zlowin,
    input  logic              Zhighin,
    input  logic              CONin,
    input  logic              Rin,
    input  logic              Gra,
    input  logic              Grb,
    input  logic              Grc,
    input  logic              PCout,
    input  logic              MDRout,
    input  logic              Zlowout,
    input  logic              Zhighout,
    input  logic              Csignout,
    input  logic              Rout,
    input  logic              BAout,
    input  logic              ADD,
    input  logic              SUB,
    input  logic              AND,
    input  logic              OR,
    input  logic              NEG,
    input  logic              NOT,
    input  logic              IncPC,
    input  logic              CONFF,
    output logic [DATA_W-1:0] BusMuxOut,
    output logic [DATA_W-1:0] PC_q,
    output logic [DATA_W-1:0] IR_q,
    output logic [DATA_W-1:0] MAR_q,
    output logic [DATA_W-1:0] MDR_q,
    output logic              CON_out
);

    logic [DATA_W-1:0]   gpr [NUM_GPR];
    logic [DATA_W-1:0]   y_q;
    logic [2*DATA_W-1:0] z_q;
    logic                con_q;

    logic [SEL_W-1:0]    sel;
    logic [DATA_W-1:0]   bus_value;
    logic [DATA_W-1:0]   imm_sext;
    alu_op_e             alu_op;
    logic [2*DATA_W-1:0] alu_result;

    // Memory write strobe is consumed by the external memory only.
    logic unused_write;
    assign unused_write = Write;

    always_comb begin
        sel = '0;
        if (asserted(Gra)) begin
            sel = IR_q[RA_LSB +: SEL_W];
        end else if (asserted(Grb)) begin
            sel = IR_q[RB_LSB +: SEL_W];
        end else if (asserted(Grc)) begin
            sel = IR_q[RC_LSB +: SEL_W];
        end
    end

    assign imm_sext = {{(DATA_W-IMM_MSB-1){IR_q[IMM_MSB]}}, IR_q[IMM_MSB:0]};

    // BAout shares the GPR slot in the priority chain; R0 reads as zero for it.
    always_comb begin
        bus_value = '0;
        if (asserted(Rout) || asserted(BAout)) begin
            bus_value = (asserted(BAout) && sel == '0) ? '0 : gpr[sel];
        end else if (asserted(PCout)) begin
            bus_value = PC_q;
        end else if (asserted(MDRout)) begin
            bus_value = MDR_q;
        end else if (asserted(Zhighout)) begin
            bus_value = z_q[2*DATA_W-1:DATA_W];
        end else if (asserted(Zlowout)) begin
            bus_value = z_q[DATA_W-1:0];
        end else if (asserted(Csignout)) begin
            bus_value = imm_sext;
        end
    end

    assign BusMuxOut = bus_value;

    always_comb begin
        alu_op = ALU_PASS;
        if (asserted(IncPC)) begin
            alu_op = ALU_INCPC;
        end else if (asserted(ADD)) begin
            alu_op = ALU_ADD;
        end else if (asserted(SUB)) begin
            alu_op = ALU_SUB;
        end else if (asserted(AND)) begin
            alu_op = ALU_AND;
        end else if (asserted(OR)) begin
            alu_op = ALU_OR;
        end else if (asserted(NEG)) begin
            alu_op = ALU_NEG;
        end else if (asserted(NOT)) begin
            alu_op = ALU_NOT;
        end
    end

    data_path_alu u_alu (
        .a      (y_q),
        .b      (bus_value),
        .op     (alu_op),
        .result (alu_result)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            PC_q  <= '0;
            IR_q  <= '0;
            MAR_q <= '0;
            MDR_q <= '0;
            y_q   <= '0;
            z_q   <= '0;
            con_q <= 1'b0;
            // NOTE: the GPR file is flops, not RAM, so clearing all of it on reset is intended.
            for (int i = 0; i < NUM_GPR; i++) begin
                gpr[i] <= '0;
            end
        end else begin
            if (asserted(PCin))  PC_q  <= bus_value;
            if (asserted(IRin))  IR_q  <= bus_value;
            if (asserted(MARin)) MAR_q <= bus_value;
            if (asserted(Yin))   y_q   <= bus_value;
            if (asserted(MDRin)) begin
                MDR_q <= (asserted(MD_read) || asserted(Read)) ? Mdatain : bus_value;
            end
            if (asserted(Zlowin))  z_q[DATA_W-1:0]          <= alu_result[DATA_W-1:0];
            if (asserted(Zhighin)) z_q[2*DATA_W-1:DATA_W]   <= alu_result[2*DATA_W-1:DATA_W];
            if (asserted(Rin))     gpr[sel]                 <= bus_value;
            if (asserted(CONin)) begin
                con_q <= branch_taken(branch_e'(IR_q[C2_LSB +: 2]), bus_value);
            end
        end
    end

    assign CON_out = con_q | asserted(CONFF);

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: directed fetch/branch/ALU steps plus
// randomized ALU, GPR and branch-condition traffic against a behavioural model.
module tb_data_path;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] Mdatain;
    logic MD_read, Read, Write, PCin, IRin, MARin, MDRin, Yin, Zlowin, Zhighin, CONin, Rin;
    logic Gra, Grb, Grc, PCout, MDRout, Zlowout, Zhighout, Csignout, Rout, BAout;
    logic ADD, SUB, AND, OR, NEG, NOT, IncPC, CONFF;
    logic [31:0] BusMuxOut, PC_q, IR_q, MAR_q, MDR_q;
    logic        CON_out;

    data_path dut (
        .clock(clock), .clear(clear), .Mdatain(Mdatain), .MD_read(MD_read), .Read(Read), .Write(Write),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zlowin(Zlowin),
        .Zhighin(Zhighin), .CONin(CONin), .Rin(Rin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .PCout(PCout), .MDRout(MDRout), .Zlowout(Zlowout), .Zhighout(Zhighout), .Csignout(Csignout),
        .Rout(Rout), .BAout(BAout), .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .NEG(NEG), .NOT(NOT),
        .IncPC(IncPC), .CONFF(CONFF), .BusMuxOut(BusMuxOut), .PC_q(PC_q), .IR_q(IR_q),
        .MAR_q(MAR_q), .MDR_q(MDR_q), .CON_out(CON_out)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y;
    logic [63:0] m_z;
    logic [31:0] m_gpr [16];
    logic        m_con;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0; m_y = 0; m_z = 0; m_con = 1'b0;
        for (int i = 0; i < 16; i++) m_gpr[i] = 0;
    endtask

    task automatic idle();
        {MD_read, Read, Write, PCin, IRin, MARin, MDRin, Yin, Zlowin, Zhighin, CONin, Rin} = '0;
        {Gra, Grb, Grc, PCout, MDRout, Zlowout, Zhighout, Csignout, Rout, BAout} = '0;
        {ADD, SUB, AND, OR, NEG, NOT, IncPC, CONFF} = '0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        idle();
    endtask

    function automatic logic [63:0] alu_model(input int op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            1: r = b + 1;
            2: r = a + b;
            3: r = a - b;
            4: r = a & b;
            5: r = a | b;
            6: r = 0 - b;
            7: r = ~b;
            default: return {32'h0, b};
        endcase
        return {{32{r[31]}}, r};
    endfunction

    function automatic logic cond_model(input logic [1:0] code, input logic [31:0] v);
        case (code)
            2'd0: return v == 0;
            2'd1: return v != 0;
            2'd2: return $signed(v) >= 0;
            default: return $signed(v) < 0;
        endcase
    endfunction

    task automatic set_op(input int op);
        case (op)
            1: IncPC = 1; 2: ADD = 1; 3: SUB = 1; 4: AND = 1;
            5: OR = 1;    6: NEG = 1; 7: NOT = 1; default: ;
        endcase
    endtask

    task automatic mem_to_mdr(input logic [31:0] v);
        MD_read = 1; MDRin = 1; Mdatain = v;
        step();
        m_mdr = v;
    endtask

    task automatic load_ir(input logic [31:0] v);
        mem_to_mdr(v);
        MDRout = 1; IRin = 1;
        step();
        m_ir = m_mdr;
    endtask

    task automatic write_gpr(input int idx, input logic [31:0] v);
        load_ir(32'(idx) << 23);
        mem_to_mdr(v);
        MDRout = 1; Gra = 1; Rin = 1;
        step();
        m_gpr[idx] = v;
    endtask

    task automatic alu_run(input int op, input logic [31:0] a, input logic [31:0] b);
        mem_to_mdr(a);
        MDRout = 1; Yin = 1;
        step();
        m_y = m_mdr;
        mem_to_mdr(b);
        MDRout = 1; Zlowin = 1; Zhighin = 1;
        set_op(op);
        step();
        m_z = alu_model(op, m_y, m_mdr);
    endtask

    task automatic check_z(input string tag);
        Zlowout = 1; #1;
        check({tag, "_zlow"}, BusMuxOut, m_z[31:0]);
        idle(); Zhighout = 1; #1;
        check({tag, "_zhigh"}, BusMuxOut, m_z[63:32]);
        idle();
    endtask

    task automatic con_from_gpr1(input string tag);
        Gra = 1; Rout = 1; CONin = 1;
        step();
        m_con = cond_model(m_ir[20:19], m_gpr[1]);
        check(tag, CON_out, m_con);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [63:0] t;
        logic [31:0] a, b, v, imm;
        int op, idx, rd;
        logic [1:0] code;

        idle();
        Mdatain = 0;
        clear = 1'b1;
        model_reset();
        #12;
        check("reset_pc", PC_q, m_pc);
        check("reset_bus", BusMuxOut, 0);
        @(negedge clock);
        clear = 1'b0;

        // Instruction fetch from PC=0
        PCout = 1; MARin = 1; IncPC = 1; Zlowin = 1; #1;
        check("fetch_bus_pc", BusMuxOut, m_pc);
        step();
        m_mar = m_pc;
        t = alu_model(1, m_y, m_pc);
        m_z[31:0] = t[31:0];
        check("fetch_mar", MAR_q, m_mar);
        Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h98900000; #1;
        check("fetch_zlow", BusMuxOut, 32'h1);
        step();
        m_pc = m_z[31:0];
        m_mdr = 32'h98900000;
        check("fetch_pc", PC_q, m_pc);
        check("fetch_mdr", MDR_q, m_mdr);
        MDRout = 1; IRin = 1;
        step();
        m_ir = m_mdr;
        check("fetch_ir", IR_q, m_ir);

        // brpl taken, then branch target arithmetic
        mem_to_mdr(32'd5);
        MDRout = 1; Gra = 1; Rin = 1;
        step();
        m_gpr[1] = 32'd5;
        Gra = 1; Rout = 1; #1;
        check("brpl_bus_r1", BusMuxOut, m_gpr[1]);
        idle();
        con_from_gpr1("brpl_taken");
        check("brpl_taken_const", CON_out, 1'b1);
        PCout = 1; Yin = 1;
        step();
        m_y = m_pc;
        imm = {{13{m_ir[18]}}, m_ir[18:0]};
        Csignout = 1; ADD = 1; Zlowin = 1; #1;
        check("csign_bus", BusMuxOut, imm);
        step();
        t = alu_model(2, m_y, imm);
        m_z[31:0] = t[31:0];
        Zlowout = 1; #1;
        check("branch_target", BusMuxOut, m_z[31:0]);
        idle();

        // brpl not taken
        mem_to_mdr(32'h80000000);
        MDRout = 1; Gra = 1; Rin = 1;
        step();
        m_gpr[1] = 32'h80000000;
        con_from_gpr1("brpl_not_taken");

        // brzr / brnz / brmi with R1 = 0
        write_gpr(1, 32'h0);
        load_ir(32'h00800000);
        con_from_gpr1("brzr");
        load_ir(32'h00880000);
        con_from_gpr1("brnz");
        load_ir(32'h00980000);
        con_from_gpr1("brmi");
        CONFF = 1; #1;
        check("conff_force", CON_out, 1'b1);
        idle();

        // Directed ALU: Y=7, bus=3
        alu_run(3, 32'd7, 32'd3);
        check_z("sub");
        alu_run(6, 32'd7, 32'd3);
        check_z("neg");

        // BAout gating of R0 and bus priority
        write_gpr(0, 32'h12345678);
        load_ir(32'h0);
        BAout = 1; Gra = 1; #1;
        check("baout_r0", BusMuxOut, 32'h0);
        idle(); BAout = 1; #1;
        check("baout_alone", BusMuxOut, 32'h0);
        idle(); Rout = 1; Gra = 1; #1;
        check("rout_r0", BusMuxOut, m_gpr[0]);
        idle();
        write_gpr(2, 32'hCAFE0002);
        BAout = 1; Gra = 1; #1;
        check("baout_r2", BusMuxOut, m_gpr[2]);
        idle(); Rout = 1; Gra = 1; PCout = 1; MDRout = 1; Zlowout = 1; #1;
        check("prio_rout", BusMuxOut, m_gpr[2]);
        idle(); PCout = 1; MDRout = 1; Csignout = 1; #1;
        check("prio_pcout", BusMuxOut, m_pc);
        idle();

        // Randomized ALU
        for (int i = 0; i < 24; i++) begin
            op = $urandom_range(0, 7);
            a = $urandom;
            b = (i % 6 == 0) ? 32'hFFFFFFFF : (i % 6 == 1) ? 32'h80000000 : $urandom;
            alu_run(op, a, b);
            check_z($sformatf("alu_rand%0d_op%0d", i, op));
        end

        // Randomized GPR writes, read back through Rc and Rb fields
        for (int i = 0; i < 12; i++) begin
            idx = $urandom_range(0, 15);
            rd  = $urandom_range(0, 15);
            v   = $urandom;
            write_gpr(idx, v);
            load_ir((32'(idx) << 15) | (32'(rd) << 19));
            Grc = 1; Rout = 1; Write = 1; #1;
            check($sformatf("gpr_rc_r%0d", idx), BusMuxOut, m_gpr[idx]);
            idle(); Grb = 1; Rout = 1; #1;
            check($sformatf("gpr_rb_r%0d", rd), BusMuxOut, m_gpr[rd]);
            idle();
        end

        // Randomized branch conditions
        for (int i = 0; i < 12; i++) begin
            code = 2'($urandom_range(0, 3));
            v = (i % 4 == 0) ? 32'h0 : $urandom;
            load_ir(32'(code) << 19);
            mem_to_mdr(v);
            MDRout = 1; CONin = 1;
            step();
            m_con = cond_model(code, v);
            check($sformatf("con_rand%0d_c%0d", i, code), CON_out, m_con);
        end

        // Mid-run clear with non-zero state everywhere
        load_ir(32'h0);
        mem_to_mdr(32'h0);
        MDRout = 1; CONin = 1; MARin = 1;
        step();
        mem_to_mdr(32'h5A5A5A5A);
        @(negedge clock);
        clear = 1'b1;
        model_reset();
        #1;
        check("clr_pc", PC_q, m_pc);
        check("clr_ir", IR_q, m_ir);
        check("clr_mar", MAR_q, m_mar);
        check("clr_mdr", MDR_q, m_mdr);
        check("clr_con", CON_out, m_con);
        check("clr_bus", BusMuxOut, 32'h0);
        Zlowout = 1; #1;
        check("clr_zlow", BusMuxOut, m_z[31:0]);
        idle(); Rout = 1; Gra = 1; #1;
        check("clr_r0", BusMuxOut, m_gpr[0]);
        idle();
        @(negedge clock);
        clear = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
